// File: rtl/buffered_mem_controller_pkg.sv
// Shared types and helpers for the buffered memory controller.
// Default widths, posted-write entry type and a log2 helper.
package mc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_entry_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/buffered_mem_controller_if.sv
// Write/read bus of the buffered memory controller.
// master drives requests, slave answers with status and read data.
interface mc_if
  import mc_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WFIFO_DEPTH = 4
);

  localparam int CNT_W = clog2(WFIFO_DEPTH) + 1;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  wr_count;
  logic              overflow;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en, rd_addr,
    input  wr_ready, rd_ready,
    input  rd_valid, rd_data,
    input  full, empty,
    input  wr_count, overflow
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_addr,
    output wr_ready, rd_ready,
    output rd_valid, rd_data,
    output full, empty,
    output wr_count, overflow
  );

endinterface

// File: rtl/mc_wr_fifo.sv
// Posted-write FIFO with a parallel address match
// over all occupied entries for read hazard detection.
module mc_wr_fifo
  import mc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ADDR_W-1:0]     push_addr,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [ADDR_W-1:0]     head_addr,
  output logic [DATA_W-1:0]     head_data,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count,
  input  logic [ADDR_W-1:0]     query_addr,
  output logic                  match
);

  localparam int PTR_W = clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             slots [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [DEPTH-1:0]   vld_nx;
  logic [PTR_W:0]     wp;
  logic [PTR_W:0]     rp;
  logic [PTR_W-1:0]   wi;
  logic [PTR_W-1:0]   ri;
  logic               push_ok;
  logic               pop_ok;

  assign wi = wp[PTR_W-1:0];
  assign ri = rp[PTR_W-1:0];

  assign full  = (wp ^ rp) == {1'b1, {PTR_W{1'b0}}};
  assign empty = (wp == rp);
  assign count = wp - rp;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_addr = slots[ri].addr;
  assign head_data = slots[ri].data;

  always_comb begin
    vld_nx = vld;
    if (pop_ok)  vld_nx[ri] = 1'b0;
    if (push_ok) vld_nx[wi] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      vld <= '0;
    end else begin
      vld <= vld_nx;
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) slots[wi] <= '{addr: push_addr, data: push_data};
  end

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && slots[i].addr == query_addr) match = 1'b1;
  end

endmodule

// File: rtl/buffered_mem_controller.sv
// Posted-write buffered RAM with a 1-cycle read port.
// Reads win the RAM port unless hazarded or the FIFO is full.
module buffered_mem_controller
  import mc_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic clk_mem,
  input  logic reset,
  mc_if.slave  bus
);

  logic                        full;
  logic                        empty;
  logic [clog2(WFIFO_DEPTH):0] count;
  logic                        push;
  logic                        pop;
  logic                        match;
  logic                        hazard;
  logic                        rd_go;
  logic [ADDR_W-1:0]           head_addr;
  logic [DATA_W-1:0]           head_data;
  logic                        rd_valid;
  logic [DATA_W-1:0]           rd_data;
  logic                        overflow;
  logic [DATA_W-1:0]           ram [2**ADDR_W];

  assign push   = bus.wr_en && !full;
  assign hazard = bus.rd_en && match;
  assign rd_go  = bus.rd_en && !hazard && !full;
  // Reset drops the head instead of letting it land in RAM
  assign pop    = !rd_go && !empty && !reset;

  mc_wr_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WFIFO_DEPTH)
  ) u_fifo (
    .clk        (clk_mem),
    .reset      (reset),
    .push       (push),
    .push_addr  (bus.wr_addr),
    .push_data  (bus.wr_data),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .query_addr (bus.rd_addr),
    .match      (match)
  );

  always_ff @(posedge clk_mem) begin
    if (pop) ram[head_addr] <= head_data;
  end

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) rd_data <= ram[bus.rd_addr];
    end
  end

  always_ff @(posedge clk_mem) begin
    if (reset)
      overflow <= 1'b0;
    else if (bus.wr_en && full)
      overflow <= 1'b1;
  end

  assign bus.wr_ready = !full;
  assign bus.rd_ready = rd_go;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_data;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.wr_count = count;
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_buffered_mem_controller.sv
// Bench for buffered_mem_controller: queue/array reference
// model checked every cycle, plus directed literal checks.
module tb_buffered_mem_controller;
  import mc_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int D  = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  logic clk_mem = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_mem = ~clk_mem;

  mc_if #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .WFIFO_DEPTH (D)
  ) bus ();

  buffered_mem_controller #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .WFIFO_DEPTH (D)
  ) dut (
    .clk_mem (clk_mem),
    .reset   (reset),
    .bus     (bus)
  );

  ent_t       q[$];
  logic [7:0] ram_m [256];
  bit         ov_m;
  bit         vld_m;
  logic [7:0] rdat_m;
  int         nvec;
  int         nfail;
  bit         last_rdy;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               n, act, exp, $time);
    end
  endtask

  function automatic bit haz(input logic [7:0] a);
    foreach (q[i]) if (q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    ov_m   = 1'b0;
    vld_m  = 1'b0;
    rdat_m = 8'h00;
  endtask

  task automatic check_state();
    chk("full", bus.full, q.size() == D);
    chk("empty", bus.empty, q.size() == 0);
    chk("wr_count", bus.wr_count, q.size());
    chk("wr_ready", bus.wr_ready, q.size() != D);
    chk("overflow", bus.overflow, ov_m);
    chk("rd_valid", bus.rd_valid, vld_m);
    chk("rd_data", bus.rd_data, rdat_m);
  endtask

  task automatic step(input bit rs, input bit we,
                      input logic [7:0] wa, input logic [7:0] wd,
                      input bit re, input logic [7:0] ra);
    bit exp_rdy;
    bit full_pre;
    reset       = rs;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.rd_addr = ra;
    #1;
    exp_rdy = re && !haz(ra) && (q.size() != D);
    chk("rd_ready", bus.rd_ready, exp_rdy);
    last_rdy = bus.rd_ready;
    @(posedge clk_mem);
    if (rs) begin
      model_reset();
    end else begin
      full_pre = (q.size() == D);
      vld_m = exp_rdy;
      if (exp_rdy) rdat_m = ram_m[ra];
      if (!exp_rdy && q.size() > 0) begin
        ram_m[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (we) begin
        if (full_pre) ov_m = 1'b1;
        else q.push_back('{a: wa, d: wd});
      end
    end
    @(negedge clk_mem);
    check_state();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 20) begin
      idle();
      k++;
    end
    chk("drain_done", bus.empty, 1'b1);
  endtask

  initial begin
    int k;
    int nw;
    logic [7:0] wd;
    logic [7:0] wa;
    logic [7:0] ra;
    bit we;
    bit re;
    bit rs;
    logic [7:0] wval [12];

    nvec  = 0;
    nfail = 0;

    // Reset with requests asserted
    reset       = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'h01;
    bus.wr_data = 8'hEE;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 8'h02;
    @(posedge clk_mem);
    @(negedge clk_mem);
    model_reset();
    check_state();
    step(1'b1, 1'b1, 8'h01, 8'hEE, 1'b1, 8'h02);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_count", bus.wr_count, 0);
    chk("rst_wr_ready", bus.wr_ready, 1'b1);

    // Give every RAM word a known value
    for (int i = 0; i < 256; i++) begin
      wa = i[7:0];
      step(1'b0, 1'b1, wa, wa ^ 8'h5A, 1'b0, 8'h00);
      if (i > 0) chk("init_count", bus.wr_count, 1);
    end
    drain();

    // Fill while reads hold the port
    for (int i = 0; i < 4; i++) begin
      wa = 8'h10 + i[7:0];
      step(1'b0, 1'b1, wa, 8'h51 + i[7:0], 1'b1, 8'h40);
    end
    chk("fill_count", bus.wr_count, 4);
    chk("fill_full", bus.full, 1'b1);
    chk("fill_wr_ready", bus.wr_ready, 1'b0);
    step(1'b0, 1'b1, 8'h14, 8'h55, 1'b1, 8'h40);
    chk("starve_stall", last_rdy, 1'b0);
    chk("ovf_set", bus.overflow, 1'b1);
    chk("starve_drained", bus.wr_count, 3);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h40);
    chk("starve_accept", last_rdy, 1'b1);
    chk("starve_data", bus.rd_data, 8'h40 ^ 8'h5A);
    drain();

    // Streaming reads
    for (int i = 0; i < 3; i++) begin
      ra = 8'h10 + i[7:0];
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ra);
      chk("stream_valid", bus.rd_valid, 1'b1);
      chk("stream_data", bus.rd_data, 8'h51 + i[7:0]);
    end
    idle();
    chk("stream_end", bus.rd_valid, 1'b0);
    chk("stream_hold", bus.rd_data, 8'h53);

    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("ovf_clear", bus.overflow, 1'b0);

    // Hazard on a buffered address
    step(1'b0, 1'b1, 8'h20, 8'hA5, 1'b1, 8'h30);
    chk("haz_pre_read", last_rdy, 1'b1);
    k = 0;
    do begin
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h20);
      if (!last_rdy) k++;
    end while (!last_rdy && k < 8);
    chk("haz_stalls", k, 1);
    chk("haz_valid", bus.rd_valid, 1'b1);
    chk("haz_data", bus.rd_data, 8'hA5);
    drain();

    // Wrap-around: 3*depth writes with interleaved reads
    nw = 0;
    k  = 0;
    while (nw < 3 * D && k < 100) begin
      re = (k % 2) == 0;
      we = (q.size() < D);
      wd = 8'($urandom);
      wa = 8'h60 + nw[7:0];
      if (we) wval[nw] = wd;
      step(1'b0, we, wa, wd, re, 8'h70);
      if (we) nw++;
      k++;
    end
    chk("wrap_writes", nw, 3 * D);
    drain();
    chk("wrap_empty", bus.empty, 1'b1);
    chk("wrap_ovf", bus.overflow, 1'b0);
    for (int i = 0; i < 3 * D; i++) begin
      ra = 8'h60 + i[7:0];
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ra);
      chk("wrap_data", bus.rd_data, wval[i]);
    end

    // Randomized traffic on a small address window
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 299) == 0);
      we = $urandom_range(0, 1) == 1;
      re = $urandom_range(0, 2) != 0;
      wa = 8'($urandom_range(0, 7));
      ra = 8'($urandom_range(0, 7));
      wd = 8'($urandom);
      if (we && re && wa == ra) ra = ra ^ 8'h01;
      step(rs, we, wa, wd, re, ra);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
